// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kyber_pkg
// Description : Shared constants, types and helpers for the Kyber uniform
//               rejection sampler (Parse / SampleNTT).
//               - KYBER_Q / KYBER_N : modulus and polynomial length
//               - BW_*              : XOF word, coefficient, address widths
//               - BUF_BYTES         : depth of the byte shift buffer
//               - S_*               : sampler FSM state encoding
//               - cand_d1/cand_d2   : 12-bit candidates from a 3-byte group
// Revision    : 1.0 - initial release
// ============================================================================
package kyber_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int KYBER_N   = 256;
    localparam int BW_DATA   = 32;
    localparam int BW_COEF   = 12;
    localparam int BW_ADDR   = 8;
    localparam int N_COEF    = KYBER_N;
    localparam int BUF_BYTES = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef logic [BW_COEF-1:0] coef_t;

    // d1 = b0 + 256*(b1 & 0xF)
    function automatic coef_t cand_d1(input logic [7:0] b0, input logic [7:0] b1);
        return {b1[3:0], b0};
    endfunction

    // d2 = (b1 >> 4) + 16*b2
    function automatic coef_t cand_d2(input logic [7:0] b1, input logic [7:0] b2);
        return {b2, b1[7:4]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/kyber_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kyber_byte_fifo
// Description : Byte shift buffer feeding the rejection sampler. Accepts a
//               4-byte little-endian word per push and drops 3 head bytes per
//               pop; push and pop may occur in the same cycle, in which case
//               the new bytes land right behind the bytes that survive the pop.
// Ports       : i_clk, i_rst  - clock, synchronous active-high reset
//               i_clr         - discard all buffered bytes
//               i_push/i_word - append i_word[7:0] first, i_word[31:24] last
//               i_pop         - remove the 3 head bytes (count must be >= 3)
//               o_count       - number of valid bytes (0..DEPTH)
//               o_b0..o_b2    - the three head bytes, o_b0 oldest
// Revision    : 1.0 - initial release
// ============================================================================
module kyber_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_push,
    input  logic [31:0] i_word,
    input  logic        i_pop,
    output logic [3:0]  o_count,
    output logic [7:0]  o_b0,
    output logic [7:0]  o_b1,
    output logic [7:0]  o_b2
);

    logic [7:0] r_buf   [DEPTH];
    logic [7:0] w_shift [DEPTH];
    logic [7:0] w_nxt   [DEPTH];
    logic [3:0] w_off   [DEPTH];
    logic [3:0] r_count;
    logic [3:0] w_base;
    logic [3:0] w_cnt_nxt;

    // w_base is where the first pushed byte goes: the fill level after any pop.
    // A slot belongs to the incoming word when its distance from w_base is
    // 0..3; the unsigned wrap makes slots in front of w_base fail that test.
    always_comb begin
        w_base    = i_pop ? (r_count - 4'd3) : r_count;
        w_cnt_nxt = w_base + (i_push ? 4'd4 : 4'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i_pop) begin
                w_shift[i] = (i < DEPTH - 3) ? r_buf[(i + 3) % DEPTH] : 8'h00;
            end else begin
                w_shift[i] = r_buf[i];
            end
            w_off[i] = 4'(i) - w_base;
            if (i_push && (w_off[i] < 4'd4)) begin
                w_nxt[i] = i_word[{w_off[i][1:0], 3'b000} +: 8];
            end else begin
                w_nxt[i] = w_shift[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            r_count <= i_clr ? 4'd0 : w_cnt_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= w_nxt[i];
            end
        end
    end

    assign o_count = r_count;
    assign o_b0    = r_buf[0];
    assign o_b1    = r_buf[1];
    assign o_b2    = r_buf[2];

endmodule
`default_nettype wire

// File: rtl/kyber_rej_sampler.sv
`default_nettype none
// ============================================================================
// Module      : kyber_rej_sampler
// Description : Kyber uniform rejection sampler. Consumes 32-bit SHAKE128
//               squeeze words and emits 256 coefficients in [0, KYBER_Q-1],
//               one write per accepted 12-bit candidate.
// Ports       : i_clk, i_rst   - clock, synchronous active-high reset
//               i_start        - pulse in IDLE to sample one polynomial
//               i_data/i_valid - XOF word, byte0 = i_data[7:0]
//               o_req          - ready; word moves when i_valid && o_req
//               o_coef/o_addr  - accepted coefficient and its index
//               o_we           - write strobe for o_coef/o_addr
//               o_busy         - run in progress (through the done pulse)
//               o_done         - one-cycle pulse after the 256th write
// Revision    : 1.0 - initial release
// ============================================================================
module kyber_rej_sampler
    import kyber_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [BW_DATA-1:0] i_data,
    input  logic               i_valid,
    output logic               o_req,
    output logic [BW_COEF-1:0] o_coef,
    output logic [BW_ADDR-1:0] o_addr,
    output logic               o_we,
    output logic               o_busy,
    output logic               o_done
);

    logic [1:0]         r_state;
    logic               r_phase;    // 0: evaluate d1, 1: evaluate d2 and pop
    logic [BW_ADDR-1:0] r_ctr;
    logic               r_we;
    logic [BW_COEF-1:0] r_coef;
    logic [BW_ADDR-1:0] r_addr;
    logic               r_done;

    logic [3:0]         w_count;
    logic [7:0]         w_b0;
    logic [7:0]         w_b1;
    logic [7:0]         w_b2;
    logic               w_run;
    logic               w_eval;
    coef_t              w_cand;
    logic               w_acc;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_clr;

    assign w_run  = (r_state == S_RUN);
    // Phase B never lacks bytes because phase A already saw three.
    assign w_eval = w_run && (w_count >= 4'd3);
    assign w_cand = r_phase ? cand_d2(w_b1, w_b2) : cand_d1(w_b0, w_b1);
    assign w_acc  = w_eval && (w_cand < coef_t'(KYBER_Q));
    assign w_last = w_acc && (r_ctr == BW_ADDR'(N_COEF - 1));

    // Ready is withheld in the final evaluation cycle so no word is taken
    // that would only be thrown away.
    assign o_req  = w_run && (w_count <= 4'(BUF_BYTES - 4)) && !w_last;
    assign w_push = i_valid && o_req;
    assign w_pop  = w_eval && r_phase && !w_last;
    // Flush on entry to RUN and on termination so leftovers never leak over.
    assign w_clr  = ((r_state == S_IDLE) && i_start) || w_last;

    kyber_byte_fifo #(
        .DEPTH (BUF_BYTES)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_word  (i_data),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_b0    (w_b0),
        .o_b1    (w_b1),
        .o_b2    (w_b2)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_phase <= 1'b0;
            r_ctr   <= '0;
            r_we    <= 1'b0;
            r_coef  <= '0;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= w_acc;
            r_done <= (r_state == S_DONE);
            if (w_acc) begin
                r_coef <= w_cand;
                r_addr <= r_ctr;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_phase <= 1'b0;
                        r_ctr   <= '0;
                    end
                end
                S_RUN: begin
                    if (w_eval) begin
                        r_phase <= ~r_phase;
                    end
                    if (w_acc) begin
                        r_ctr <= r_ctr + 1'b1;
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // DONE overlaps the last write, so the done pulse is registered one
    // cycle later; busy covers that pulse and drops with it.
    assign o_we   = r_we;
    assign o_coef = r_coef;
    assign o_addr = r_addr;
    assign o_done = r_done;
    assign o_busy = (r_state != S_IDLE) || r_done;

endmodule
`default_nettype wire

// File: tb/tb_kyber_rej_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_kyber_rej_sampler
// Description : Self-checking bench for kyber_rej_sampler: directed vector
//               table for the candidate compare, plus sequences for full
//               polynomials, d1 termination, all-reject streams, backpressure
//               against a Parse reference model, and control misuse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kyber_rej_sampler;

    logic        i_clk   = 1'b0;
    logic        i_rst   = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_data  = 32'h0;
    logic        i_valid = 1'b0;
    logic        o_req;
    logic [11:0] o_coef;
    logic [7:0]  o_addr;
    logic        o_we;
    logic        o_busy;
    logic        o_done;

    kyber_rej_sampler dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_req   (o_req),
        .o_coef  (o_coef),
        .o_addr  (o_addr),
        .o_we    (o_we),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- word feeder ----------------
    logic [31:0] feed_words [256];
    int          feed_len  = 0;
    bit          feed_en   = 1'b0;
    bit          tail_en   = 1'b0;
    logic [31:0] tail_word = 32'h0;
    int          duty      = 100;
    int          feed_idx  = 0;
    int          xfer_cnt  = 0;
    bit          hs;

    always begin
        @(negedge i_clk);
        hs = i_valid && o_req;
        @(posedge i_clk);
        #1;
        if (hs) begin
            feed_idx++;
            xfer_cnt++;
        end
        if (!feed_en) begin
            i_valid = 1'b0;
        end else if (hs || !i_valid) begin
            if (feed_idx < feed_len) begin
                i_data  = feed_words[feed_idx];
                i_valid = ($urandom_range(99) < duty);
            end else if (tail_en) begin
                i_data  = tail_word;
                i_valid = ($urandom_range(99) < duty);
            end else begin
                i_valid = 1'b0;
            end
        end
    end

    // ---------------- output monitor ----------------
    int wq_addr [$];
    int wq_coef [$];
    int cyc         = 0;
    int last_we_cyc = 0;
    int done_cyc    = 0;
    int done_cnt    = 0;
    bit seen_last   = 1'b0;
    int req_late    = 0;

    always @(negedge i_clk) begin
        cyc++;
        if (o_we && (o_addr == 8'd255)) seen_last = 1'b1;
        if (seen_last && o_req) req_late++;
        if (o_we) begin
            wq_addr.push_back(int'(o_addr));
            wq_coef.push_back(int'(o_coef));
            last_we_cyc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- helpers ----------------
    int exp_coef [256];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_coef.delete();
        done_cnt  = 0;
        seen_last = 1'b0;
        req_late  = 0;
        feed_idx  = 0;
        xfer_cnt  = 0;
    endtask

    task automatic apply_reset(input string tag);
        i_rst   = 1'b1;
        feed_en = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk({tag, "_we"},   int'(o_we),   0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_req"},  int'(o_req),  0);
        chk({tag, "_done"}, int'(o_done), 0);
        chk({tag, "_addr"}, int'(o_addr), 0);
        chk({tag, "_coef"}, int'(o_coef), 0);
        tick();
        i_rst = 1'b0;
        tick();
        tick();
        clear_mon();
    endtask

    task automatic wait_writes(input int n, input int maxc, input string tag);
        int c = 0;
        while ((wq_addr.size() < n) && (c < maxc)) begin
            @(negedge i_clk);
            c++;
        end
        if (wq_addr.size() < n) chk(tag, wq_addr.size(), n);
    endtask

    task automatic wait_done(input int maxc, input string tag);
        int c = 0;
        while ((done_cnt == 0) && (c < maxc)) begin
            @(negedge i_clk);
            c++;
        end
        if (done_cnt == 0) chk(tag, 0, 1);
    endtask

    function automatic int stream_byte(input int j);
        logic [31:0] w;
        int idx;
        idx = j / 4;
        w = (idx < feed_len) ? feed_words[idx] : tail_word;
        return int'((w >> (8 * (j % 4))) & 32'hFF);
    endfunction

    // Reference Parse over the byte stream the feeder presents.
    task automatic build_model();
        int j = 0;
        int n = 0;
        int b0, b1, b2, d1, d2;
        while ((n < 256) && (j < 4096)) begin
            b0 = stream_byte(j);
            b1 = stream_byte(j + 1);
            b2 = stream_byte(j + 2);
            d1 = b0 + 256 * (b1 % 16);
            d2 = (b1 / 16) + 16 * b2;
            if (d1 < 3329) begin exp_coef[n] = d1; n++; end
            if ((n < 256) && (d2 < 3329)) begin exp_coef[n] = d2; n++; end
            j += 3;
        end
    endtask

    task automatic cmp_model(input string tag, input int n);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            if ((k >= wq_coef.size()) || (wq_coef[k] != exp_coef[k]) || (wq_addr[k] != k)) bad++;
        end
        chk(tag, bad, 0);
    endtask

    function automatic int got_coef(input int k);
        return (k < wq_coef.size()) ? wq_coef[k] : -1;
    endfunction

    function automatic int got_addr(input int k);
        return (k < wq_addr.size()) ? wq_addr[k] : -1;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [11:0] e0;
        logic [11:0] e1;
        logic [11:0] e2;
        logic [11:0] e3;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int busy_low, req0, req1;
        int e [4];

        // bytes 01 0D D0 | 01 D0 CF: d1=3329 rej, d2=3328, then 1, 3325
        vecs[0] = '{32'h01D00D01, 32'h0000CFD0, 12'd3328, 12'd1,    12'd3325, 12'd0};
        // FF FF FF rejects both, then FF 00 00 -> 255, 0
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 12'd255,  12'd0,    12'd0,    12'd0};
        // 00 0D D0 -> 3328, 3328; 12 34 56 -> 1042, 1379
        vecs[2] = '{32'h12D00D00, 32'h00005634, 12'd3328, 12'd3328, 12'd1042, 12'd1379};
        // 01 0D D1 -> 3329, 3344 both rejected; FF 0C 00 -> 3327, 0
        vecs[3] = '{32'hFFD10D01, 32'h0000000C, 12'd3327, 12'd0,    12'd0,    12'd0};
        // AB CD EF -> 3499, 3836 rejected; 01 23 45 -> 769, 1106
        vecs[4] = '{32'h01EFCDAB, 32'h00004523, 12'd769,  12'd1106, 12'd0,    12'd0};

        tick();
        tick();
        apply_reset("reset");

        // ---- table-driven candidate compare ----
        for (int v = 0; v < 5; v++) begin
            feed_words[0] = vecs[v].w0;
            feed_words[1] = vecs[v].w1;
            feed_len  = 2;
            tail_en   = 1'b1;
            tail_word = 32'h0;
            duty      = 100;
            pulse_start();
            feed_en = 1'b1;
            wait_writes(4, 60, $sformatf("vec%0d_timeout", v));
            e[0] = int'(vecs[v].e0);
            e[1] = int'(vecs[v].e1);
            e[2] = int'(vecs[v].e2);
            e[3] = int'(vecs[v].e3);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("vec%0d_coef%0d", v, k), got_coef(k), e[k]);
                chk($sformatf("vec%0d_addr%0d", v, k), got_addr(k), k);
            end
            apply_reset($sformatf("vec%0d_rst", v));
        end

        // ---- all-zero polynomial, exactly 96 words, stray i_start mid-run ----
        for (int i = 0; i < 256; i++) feed_words[i] = 32'h0;
        feed_len = 96;
        tail_en  = 1'b0;
        duty     = 100;
        build_model();
        pulse_start();
        feed_en = 1'b1;
        wait_writes(50, 2000, "zero_mid_timeout");
        pulse_start();
        wait_done(3000, "zero_done_timeout");
        repeat (3) tick();
        chk("zero_writes", wq_addr.size(), 256);
        cmp_model("zero_seq", 256);
        chk("zero_xfers", xfer_cnt, 96);
        chk("zero_done_pulses", done_cnt, 1);
        chk("zero_done_lag", done_cyc - last_we_cyc, 1);
        chk("zero_busy_after", int'(o_busy), 0);
        apply_reset("zero_rst");

        // ---- termination on a d1: FF FF 00 gives one d2 accept first ----
        for (int i = 0; i < 256; i++) feed_words[i] = 32'h0;
        feed_words[0] = 32'h0000FFFF;
        feed_len  = 1;
        tail_en   = 1'b1;
        tail_word = 32'h0;
        duty      = 100;
        build_model();
        pulse_start();
        feed_en = 1'b1;
        wait_done(3000, "d1_done_timeout");
        repeat (10) tick();
        chk("d1_writes", wq_addr.size(), 256);
        chk("d1_first", got_coef(0), 15);
        chk("d1_last_addr", got_addr(255), 255);
        cmp_model("d1_seq", 256);
        chk("d1_done_lag", done_cyc - last_we_cyc, 1);
        chk("d1_req_after_last", req_late, 0);
        chk("d1_done_pulses", done_cnt, 1);
        chk("d1_busy_after", int'(o_busy), 0);
        apply_reset("d1_rst");

        // ---- all-reject stream: no writes, stays busy ----
        feed_len  = 0;
        tail_en   = 1'b1;
        tail_word = 32'hFFFFFFFF;
        duty      = 100;
        pulse_start();
        feed_en  = 1'b1;
        busy_low = 0;
        req0     = 0;
        req1     = 0;
        repeat (500) begin
            @(negedge i_clk);
            if (!o_busy) busy_low++;
            if (o_req) req1++;
            else req0++;
        end
        chk("ff_writes", wq_addr.size(), 0);
        chk("ff_busy_low", busy_low, 0);
        chk("ff_req_low_seen", int'(req0 > 0), 1);
        chk("ff_req_high_seen", int'(req1 > 0), 1);
        chk("ff_done", done_cnt, 0);
        tick();
        apply_reset("ff_rst");

        // ---- backpressure run aborted by reset at write 100 ----
        for (int i = 0; i < 256; i++) feed_words[i] = $urandom;
        feed_len  = 250;
        tail_en   = 1'b1;
        tail_word = 32'h0;
        duty      = 30;
        build_model();
        pulse_start();
        feed_en = 1'b1;
        wait_writes(101, 20000, "rnd1_timeout");
        cmp_model("rnd1_seq", 101);
        apply_reset("rnd1_rst");

        // ---- fresh start after the abort, full backpressured polynomial ----
        for (int i = 0; i < 256; i++) feed_words[i] = $urandom;
        build_model();
        pulse_start();
        feed_en = 1'b1;
        wait_done(20000, "rnd2_done_timeout");
        repeat (3) tick();
        chk("rnd2_writes", wq_addr.size(), 256);
        chk("rnd2_first_addr", got_addr(0), 0);
        cmp_model("rnd2_seq", 256);
        chk("rnd2_done_pulses", done_cnt, 1);
        chk("rnd2_busy_after", int'(o_busy), 0);
        feed_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
